piso_shift8: RTL and testbench
==============================

// Module: piso_shift8
// PURPOSE
//   Parallel-in/serial-out stage directly downstream of the Oen8bit output register.
//   Captures one WIDTH-bit word from the register's data_out via a load/ready handshake.
//   Shifts the word out one bit per clk on ser_out, with busy/done status.
//   Feeds serial-link and LED-chaser experiments on the lab board.
// PARAMETERS
//   WIDTH      8   word width in bits; legal range >= 2
//   MSB_FIRST  1   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// PORTS
//   clk      input   1      single clock; all state changes on its rising edge
//   clr      input   1      reset; asynchronous, active-low (0 = reset)
//   data_in  input   WIDTH  parallel word from the upstream register's data_out
//   load     input   1      word-valid strobe; driven by the upstream Oen
//   ready    output  1      stage can accept a word this cycle
//   ser_out  output  1      serial data bit
//   busy     output  1      shift in progress
//   done     output  1      one-cycle pulse after the last bit has been sent
// BEHAVIOUR
//   - Reset (clr=0, asynchronous): state=IDLE, shreg=0, cnt=0, ser_out=0,
//     busy=0, done=0, ready=1. Takes effect immediately, without waiting for clk.
//   - FSM states: IDLE, SHIFT, DONE. All outputs are registered or decoded from
//     state only; no combinational path from load to ready.
//   - IDLE: ready=1, ser_out=0.
//     On an edge where load=1: shreg<=data_in, cnt<=0, go to SHIFT.
//     The word is accepted only in IDLE.
//   - SHIFT: busy=1, ready=0, ser_out = current head bit of shreg
//     (MSB if MSB_FIRST=1, else LSB).
//     Each edge shifts shreg by one toward the head; vacated bits fill with 0.
//     Each edge also increments cnt. When cnt==WIDTH-1, the next state is DONE.
//   - Latency: the first bit appears on ser_out the cycle after acceptance.
//     Bit k (k=0..WIDTH-1 in send order) is valid during cycle k+1.
//     busy stays high for exactly WIDTH cycles.
//   - DONE: done=1, busy=0, ready=0, ser_out=0 for exactly one cycle, then IDLE.
//     Throughput is one word per WIDTH+2 cycles, counting the IDLE accept cycle.
//   - load=1 while in SHIFT or DONE is ignored: data_in is not sampled and no
//     error is flagged. Upstream must keep the word stable until it sees ready=1.
//   - load held high continuously: the next word is captured on the first IDLE
//     edge after DONE, giving back-to-back words with a single idle gap.
//   - Reset mid-SHIFT: the partial word is discarded and no done pulse is issued.
//     After clr is released, the first edge starts in IDLE.
//   - Counter width: cnt is $clog2(WIDTH) bits. It never wraps, because SHIFT
//     exits at WIDTH-1.
//   - data_in of X/Z while load=0 has no effect on any output.
// STRUCTURE
//   - piso_pkg.vh: state encodings (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2)
//     and the CNT_W function (clog2). Shared with a future serial receiver.
//   - One sub-module is natural: piso_bit_counter. Inputs: clk, clr, clear, en.
//     Outputs: cnt and last (cnt==WIDTH-1).
//   - Top level holds the FSM, shreg and output decode.
// TESTING
//   1. Reset: clr=0 mid-cycle -> ready=1, busy=0, done=0, ser_out=0, with no clk
//      edge required.
//   2. load=1, data_in=8'b00100011, MSB_FIRST=1 -> ser_out over cycles 1..8 is
//      0,0,1,0,0,0,1,1; done=1 in cycle 9; ready=1 in cycle 10.
//   3. During SHIFT of 8'hA5, pulse load with data_in=8'hFF -> ser_out still
//      1,0,1,0,0,1,0,1 and no extra done pulse.
//   4. Send 8'b11110000, assert clr=0 at bit 4 -> outputs return to reset values
//      at once. After release, load 8'h0F -> 0,0,0,0,1,1,1,1.
//   5. MSB_FIRST=0, data_in=8'b11000110 -> 0,1,1,0,0,0,1,1.
//   6. load held at 1, words 8'h4C then 8'h70 -> exactly one IDLE cycle between
//      the two done pulses, each done 10 cycles apart.

Source files
------------

// File: rtl/piso_shift8_pkg.sv
// Shared definitions for the PISO shift stage and a future serial receiver:
// FSM state encodings and the bit-counter width helper.
package piso_shift8_pkg;

   // Encodings are fixed so a receiver decoding the same link can reuse them.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } piso_state_e;

   // Width of a counter that must reach width-1; at least one bit.
   function automatic int unsigned cnt_w(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/piso_shift8_if.sv
// Word-load handshake and serial/status outputs of the PISO stage.
// The upstream register drives data_in/load; the stage drives the rest.
interface piso_shift8_if #(
   parameter int unsigned WIDTH = 8
);

   logic [WIDTH-1:0] data_in;
   logic             load;
   logic             ready;
   logic             ser_out;
   logic             busy;
   logic             done;

   modport master (
      output data_in,
      output load,
      input  ready,
      input  ser_out,
      input  busy,
      input  done
   );

   modport slave (
      input  data_in,
      input  load,
      output ready,
      output ser_out,
      output busy,
      output done
   );

endinterface

// File: rtl/piso_shift8_bit_counter.sv
// Bit-position counter for the PISO stage. Clears to zero, counts up while
// enabled and flags the final bit position (WIDTH-1).
module piso_shift8_bit_counter
   import piso_shift8_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned CntW = cnt_w(WIDTH)
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            clear_i,
   input  logic            en_i,
   output logic [CntW-1:0] cnt_o,
   output logic            last_o
);

   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] cnt_d;

   // Next count: clear has priority over enable.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Count register, asynchronously cleared by the stage reset.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign last_o = (cnt_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/piso_shift8.sv
// Parallel-in/serial-out stage. Accepts one word in IDLE via load/ready,
// shifts it out one bit per clock while busy, then pulses done for a cycle.
// WIDTH must be at least 2.
module piso_shift8
   import piso_shift8_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         clr,
   piso_shift8_if.slave bus
);

   localparam int unsigned CntW = cnt_w(WIDTH);

   piso_state_e      state_q;
   piso_state_e      state_d;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;
   logic [WIDTH-1:0] shreg_shifted;
   logic             head_bit;
   logic [CntW-1:0]  cnt;
   logic             cnt_last;
   logic             cnt_clear;
   logic             cnt_en;

   // Counter is held at zero outside SHIFT and stops at WIDTH-1 so it never wraps.
   assign cnt_clear = (state_q != StShift);
   assign cnt_en    = (state_q == StShift) && !cnt_last;

   piso_shift8_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk     (clk),
      .clr     (clr),
      .clear_i (cnt_clear),
      .en_i    (cnt_en),
      .cnt_o   (cnt),
      .last_o  (cnt_last)
   );

   // Head bit and one-step shift toward the head, vacated bit filled with 0.
   always_comb begin
      if (MSB_FIRST) begin
         head_bit      = shreg_q[WIDTH-1];
         shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
         head_bit      = shreg_q[0];
         shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
      end
   end

   // Next state and shift register; data_in is only sampled on an IDLE accept.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      case (state_q)
         StIdle: begin
            if (bus.load) begin
               state_d = StShift;
               shreg_d = bus.data_in;
            end
         end
         StShift: begin
            shreg_d = shreg_shifted;
            if (cnt_last) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and shift register, asynchronously reset to an empty IDLE stage.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= StIdle;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
      end
   end

   // Outputs decoded from state only, so load never reaches ready combinationally.
   always_comb begin
      bus.ready   = (state_q == StIdle);
      bus.busy    = (state_q == StShift);
      bus.done    = (state_q == StDone);
      bus.ser_out = (state_q == StShift) ? head_bit : 1'b0;
   end

   // The count value itself is only consumed through last_o.
   logic unused_cnt;
   assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_piso_shift8.sv
// Bench for piso_shift8: one MSB-first and one LSB-first instance see the
// same stimulus; expected serial bits are queued at load and popped as the
// DUTs shift.
module tb_piso_shift8;

   logic clk;
   logic clr;

   int n_checks = 0;
   int n_errors = 0;

   bit q_m[$];
   bit q_l[$];
   int exp_done_m = 0;
   int got_done_m = 0;
   int exp_done_l = 0;
   int got_done_l = 0;

   piso_shift8_if #(.WIDTH(8)) bus_m ();
   piso_shift8_if #(.WIDTH(8)) bus_l ();

   piso_shift8 #(
      .WIDTH     (8),
      .MSB_FIRST (1'b1)
   ) u_dut_m (
      .clk (clk),
      .clr (clr),
      .bus (bus_m)
   );

   piso_shift8 #(
      .WIDTH     (8),
      .MSB_FIRST (1'b0)
   ) u_dut_l (
      .clk (clk),
      .clr (clr),
      .bus (bus_l)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic ld, input logic [7:0] d);
      bus_m.load    = ld;
      bus_m.data_in = d;
      bus_l.load    = ld;
      bus_l.data_in = d;
   endtask

   task automatic push_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) q_m.push_back(w[i]);
      for (int i = 0; i < 8; i++) q_l.push_back(w[i]);
      exp_done_m++;
      exp_done_l++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_status(input string tag, input logic r, input logic b, input logic d);
      check_val({tag, "_ready_m"}, 32'(bus_m.ready), 32'(r));
      check_val({tag, "_busy_m"},  32'(bus_m.busy),  32'(b));
      check_val({tag, "_done_m"},  32'(bus_m.done),  32'(d));
      check_val({tag, "_ready_l"}, 32'(bus_l.ready), 32'(r));
      check_val({tag, "_busy_l"},  32'(bus_l.busy),  32'(b));
      check_val({tag, "_done_l"},  32'(bus_l.done),  32'(d));
   endtask

   task automatic check_reset(input string tag);
      check_status(tag, 1'b1, 1'b0, 1'b0);
      check_val({tag, "_ser_m"}, 32'(bus_m.ser_out), 32'(0));
      check_val({tag, "_ser_l"}, 32'(bus_l.ser_out), 32'(0));
   endtask

   // Full transfer from IDLE; optionally pulses load with 8'hFF mid-shift.
   task automatic run_word(input logic [7:0] w, input bit inject);
      check_status("pre", 1'b1, 1'b0, 1'b0);
      drive(1'b1, w);
      push_word(w);
      tick();
      drive(1'b0, 'x);
      for (int k = 1; k <= 8; k++) begin
         check_status($sformatf("shift_c%0d", k), 1'b0, 1'b1, 1'b0);
         if (inject && k == 3) drive(1'b1, 8'hFF);
         if (inject && k == 4) drive(1'b0, 'x);
         tick();
      end
      check_status("done_c9", 1'b0, 1'b0, 1'b1);
      tick();
      check_status("idle_c10", 1'b1, 1'b0, 1'b0);
   endtask

   // Scoreboard: pop one expected bit per busy cycle, count done pulses.
   always @(negedge clk) begin
      if (clr) begin
         if (bus_m.busy) begin
            if (q_m.size() == 0) check_val("ser_m_extra", 32'(q_m.size()), 32'(1));
            else check_val("ser_m", 32'(bus_m.ser_out), 32'(q_m.pop_front()));
         end else begin
            check_val("ser_m_quiet", 32'(bus_m.ser_out), 32'(0));
         end
         if (bus_m.done) got_done_m++;
         if (bus_l.busy) begin
            if (q_l.size() == 0) check_val("ser_l_extra", 32'(q_l.size()), 32'(1));
            else check_val("ser_l", 32'(bus_l.ser_out), 32'(q_l.pop_front()));
         end else begin
            check_val("ser_l_quiet", 32'(bus_l.ser_out), 32'(0));
         end
         if (bus_l.done) got_done_l++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      int ready_cnt;
      int done_cnt;
      int done_first;
      int done_second;

      clr = 1'b1;
      drive(1'b0, 8'h00);
      #1 clr = 1'b0;
      #1 check_reset("rst_async");
      tick();
      check_reset("rst_hold");
      #2 clr = 1'b1;
      tick();

      run_word(8'b0010_0011, 1'b0);
      run_word(8'hA5, 1'b1);
      run_word(8'b1100_0110, 1'b0);

      // Abort a word at bit 4 with an asynchronous reset.
      check_status("abort_pre", 1'b1, 1'b0, 1'b0);
      drive(1'b1, 8'b1111_0000);
      push_word(8'b1111_0000);
      tick();
      drive(1'b0, 'x);
      repeat (4) tick();
      #2 clr = 1'b0;
      q_m.delete();
      q_l.delete();
      exp_done_m = got_done_m;
      exp_done_l = got_done_l;
      #1 check_reset("rst_mid");
      tick();
      check_reset("rst_mid_hold");
      #2 clr = 1'b1;
      tick();
      run_word(8'h0F, 1'b0);

      // Back-to-back words with load held high.
      check_status("b2b_pre", 1'b1, 1'b0, 1'b0);
      drive(1'b1, 8'h4C);
      push_word(8'h4C);
      tick();
      drive(1'b1, 8'h70);
      push_word(8'h70);
      ready_cnt   = 0;
      done_cnt    = 0;
      done_first  = 0;
      done_second = 0;
      for (int c = 1; c <= 19; c++) begin
         if (bus_m.done) begin
            done_cnt++;
            if (done_cnt == 1) done_first = c;
            if (done_cnt == 2) done_second = c;
         end
         if (bus_m.ready) ready_cnt++;
         if (c == 11) drive(1'b0, 'x);
         tick();
      end
      check_val("b2b_done_cnt", 32'(done_cnt), 32'(2));
      check_val("b2b_done_first", 32'(done_first), 32'(9));
      check_val("b2b_done_second", 32'(done_second), 32'(19));
      check_val("b2b_idle_gap", 32'(ready_cnt), 32'(1));
      check_status("b2b_end", 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 30 && (q_m.size() != 0 || q_l.size() != 0); i++) tick();
      check_val("drain_m", 32'(q_m.size()), 32'(0));
      check_val("drain_l", 32'(q_l.size()), 32'(0));
      check_val("done_count_m", 32'(got_done_m), 32'(exp_done_m));
      check_val("done_count_l", 32'(got_done_l), 32'(exp_done_l));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
